// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited in-order
// imem requests and buffers (pc, inst) pairs for decode; redirects flush and drop stale responses.
module pc_fetch_unit #(
    parameter int          WIDTH_PC   = 32,
    parameter int          WIDTH_INST = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FQ_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH_PC-1:0]   npc,
    input  logic                  redirect,
    input  logic [WIDTH_PC-1:0]   redirect_pc,
    output logic [WIDTH_PC-1:0]   current_pc,
    output logic                  stop_IF,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [WIDTH_PC-1:0]   imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [WIDTH_INST-1:0] imem_resp_inst,
    output logic                  if_valid,
    output logic [WIDTH_PC-1:0]   if_pc,
    output logic [WIDTH_INST-1:0] if_inst,
    input  logic                  id_ready
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [WIDTH_PC-1:0]   r_current_pc;
    logic [WIDTH_PC-1:0]   r_pend_pc [FQ_DEPTH];
    logic [PW-1:0]         r_pend_wr;
    logic [PW-1:0]         r_pend_rd;
    logic [WIDTH_PC-1:0]   r_fq_pc   [FQ_DEPTH];
    logic [WIDTH_INST-1:0] r_fq_inst [FQ_DEPTH];
    logic [PW-1:0]         r_fq_wr;
    logic [PW-1:0]         r_fq_rd;
    logic [CW-1:0]         r_fq_count;
    logic [CW-1:0]         r_in_flight;
    logic [CW-1:0]         r_drop_cnt;

    logic [CW+1:0]         w_credit_used;
    logic                  w_can_issue;
    logic                  w_req_fire;
    logic                  w_resp_acc;
    logic                  w_resp_drop;
    logic                  w_fq_pop;
    logic [CW:0]           w_outstanding;
    logic [CW-1:0]         w_drop_redirect;

    // Every slot is owed to something: an in-flight request, a response still to be
    // dropped, or a queued entry. That bound is what keeps the fetch queue from overflowing.
    assign w_credit_used = {2'b00, r_in_flight} + {2'b00, r_drop_cnt} + {2'b00, r_fq_count};
    assign w_can_issue   = w_credit_used < (CW+2)'(FQ_DEPTH);

    assign imem_req_valid = w_can_issue & ~redirect & rst_n;
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign stop_IF        = ~w_req_fire;
    assign imem_req_addr  = r_current_pc;
    assign current_pc     = r_current_pc;

    assign w_resp_drop = imem_resp_valid & (r_drop_cnt != '0) & ~redirect;
    assign w_resp_acc  = imem_resp_valid & (r_drop_cnt == '0) & ~redirect;
    assign w_fq_pop    = if_valid & id_ready & ~redirect;

    assign w_outstanding   = {1'b0, r_drop_cnt} + {1'b0, r_in_flight};
    assign w_drop_redirect = (imem_resp_valid && w_outstanding != '0) ?
                             CW'(w_outstanding - (CW+1)'(1)) : CW'(w_outstanding);

    assign if_valid = (r_fq_count != '0);
    assign if_pc    = if_valid ? r_fq_pc[r_fq_rd]   : '0;
    assign if_inst  = if_valid ? r_fq_inst[r_fq_rd] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_current_pc <= WIDTH_PC'(RESET_PC);
            r_pend_wr    <= '0;
            r_pend_rd    <= '0;
            r_fq_wr      <= '0;
            r_fq_rd      <= '0;
            r_fq_count   <= '0;
            r_in_flight  <= '0;
            r_drop_cnt   <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_pend_pc[i] <= '0;
                r_fq_pc[i]   <= '0;
                r_fq_inst[i] <= '0;
            end
        end else if (redirect) begin
            r_current_pc <= redirect_pc;
            r_pend_wr    <= '0;
            r_pend_rd    <= '0;
            r_fq_wr      <= '0;
            r_fq_rd      <= '0;
            r_fq_count   <= '0;
            r_in_flight  <= '0;
            r_drop_cnt   <= w_drop_redirect;
        end else begin
            if (w_req_fire) begin
                r_current_pc         <= npc;
                r_pend_pc[r_pend_wr] <= r_current_pc;
                r_pend_wr            <= r_pend_wr + PW'(1);
            end
            if (w_resp_acc) begin
                r_fq_pc[r_fq_wr]   <= r_pend_pc[r_pend_rd];
                r_fq_inst[r_fq_wr] <= imem_resp_inst;
                r_fq_wr            <= r_fq_wr + PW'(1);
                r_pend_rd          <= r_pend_rd + PW'(1);
            end
            if (w_fq_pop) begin
                r_fq_rd <= r_fq_rd + PW'(1);
            end
            if (w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            r_in_flight <= r_in_flight + CW'(w_req_fire) - CW'(w_resp_acc);
            r_fq_count  <= r_fq_count + CW'(w_resp_acc) - CW'(w_fq_pop);
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a directed cycle table, a mid-flight reset sequence and a
// randomized run against a queue-based reference model with an in-order memory.
module tb_pc_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] current_pc;
    logic        stop_IF;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;

    int errors = 0;
    int checks = 0;

    pc_fetch_unit #(.WIDTH_PC(32), .WIDTH_INST(32), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .npc(npc), .redirect(redirect), .redirect_pc(redirect_pc),
        .current_pc(current_pc), .stop_IF(stop_IF), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_inst(imem_resp_inst),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " if_valid"}, {31'b0, if_valid}, 32'd0);
        chk({tag, " req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, " stop_IF"}, {31'b0, stop_IF}, 32'd1);
        chk({tag, " current_pc"}, current_pc, 32'h0);
        chk({tag, " if_pc"}, if_pc, 32'h0);
        chk({tag, " if_inst"}, if_inst, 32'h0);
    endtask

    typedef struct packed {
        logic        rd;
        logic [31:0] rpc;
        logic        idr;
        logic        rdy;
        logic        rv;
        logic [31:0] raddr;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_ifpc;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic [31:0] rpc, input logic idr,
                                input logic rdy, input logic rv, input logic [31:0] raddr,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_ifv, input logic [31:0] e_ifpc);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.idr = idr; v.rdy = rdy; v.rv = rv; v.raddr = raddr;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_ifpc = e_ifpc;
        return v;
    endfunction

    // Reference model state: plain queues for pending PCs and the fetch queue.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    logic [31:0] m_fq_pc[$];
    logic [31:0] m_fq_inst[$];
    int          m_drop;
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    int          mem_last_due;
    int          cyc;

    task automatic model_clear();
        m_pc = 32'h0;
        m_pend.delete(); m_fq_pc.delete(); m_fq_inst.delete();
        m_drop = 0;
        mem_addr.delete(); mem_due.delete();
        mem_last_due = 0;
    endtask

    task automatic random_cycle();
        logic        exp_req, fire, pop;
        logic [31:0] issued;
        redirect       = ($urandom_range(0, 11) == 0);
        redirect_pc    = $urandom & 32'hFFFF_FFFC;
        id_ready       = ($urandom_range(0, 3) != 0);
        imem_req_ready = ($urandom_range(0, 3) != 0);
        npc            = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
        if (mem_addr.size() != 0 && mem_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = inst_of(mem_addr[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_inst  = $urandom;
        end
        #1;
        exp_req = ((m_pend.size() + m_drop + m_fq_pc.size()) < DEPTH) && !redirect;
        fire    = exp_req && imem_req_ready;
        chk("rnd req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        chk("rnd stop_IF", {31'b0, stop_IF}, {31'b0, !fire});
        chk("rnd req_addr", imem_req_addr, m_pc);
        chk("rnd current_pc", current_pc, m_pc);
        chk("rnd if_valid", {31'b0, if_valid}, {31'b0, m_fq_pc.size() != 0});
        if (m_fq_pc.size() != 0) begin
            chk("rnd if_pc", if_pc, m_fq_pc[0]);
            chk("rnd if_inst", if_inst, m_fq_inst[0]);
        end
        pop    = (m_fq_pc.size() != 0) && id_ready;
        issued = m_pc;
        if (redirect) begin
            m_drop = m_drop + m_pend.size() - (imem_resp_valid ? 1 : 0);
            if (m_drop < 0) m_drop = 0;
            m_pend.delete(); m_fq_pc.delete(); m_fq_inst.delete();
            m_pc = redirect_pc;
        end else begin
            if (pop) begin
                void'(m_fq_pc.pop_front());
                void'(m_fq_inst.pop_front());
            end
            if (imem_resp_valid) begin
                if (m_drop > 0) m_drop--;
                else if (m_pend.size() != 0) begin
                    m_fq_pc.push_back(m_pend.pop_front());
                    m_fq_inst.push_back(imem_resp_inst);
                end
            end
            if (fire) begin
                m_pend.push_back(m_pc);
                m_pc = npc;
            end
        end
        if (imem_resp_valid) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
        end
        if (fire) begin
            int due = cyc + 1 + $urandom_range(0, 2);
            if (due < mem_last_due) due = mem_last_due;
            mem_last_due = due;
            mem_addr.push_back(issued);
            mem_due.push_back(due);
        end
        @(negedge clk);
        cyc++;
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = mk(0, 0,     1, 1, 0, 0,      1, 32'h000, 0, 0);
        vecs[1]  = mk(0, 0,     1, 1, 1, 32'h0,  1, 32'h004, 0, 0);
        vecs[2]  = mk(0, 0,     1, 1, 1, 32'h4,  0, 32'h008, 1, 32'h0);
        vecs[3]  = mk(0, 0,     1, 1, 0, 0,      1, 32'h008, 1, 32'h4);
        vecs[4]  = mk(0, 0,     1, 1, 1, 32'h8,  1, 32'h00C, 0, 0);
        vecs[5]  = mk(0, 0,     0, 1, 1, 32'hC,  0, 32'h010, 1, 32'h8);
        vecs[6]  = mk(0, 0,     0, 1, 0, 0,      0, 32'h010, 1, 32'h8);
        vecs[7]  = mk(0, 0,     1, 1, 0, 0,      0, 32'h010, 1, 32'h8);
        vecs[8]  = mk(0, 0,     0, 0, 0, 0,      1, 32'h010, 1, 32'hC);
        vecs[9]  = mk(0, 0,     0, 0, 0, 0,      1, 32'h010, 1, 32'hC);
        vecs[10] = mk(0, 0,     0, 1, 0, 0,      1, 32'h010, 1, 32'hC);
        vecs[11] = mk(0, 0,     0, 1, 0, 0,      0, 32'h014, 1, 32'hC);
        vecs[12] = mk(1, 32'h100, 1, 1, 1, 32'h10, 0, 32'h014, 1, 32'hC);
        vecs[13] = mk(0, 0,     1, 1, 0, 0,      1, 32'h100, 0, 0);
        vecs[14] = mk(0, 0,     1, 1, 1, 32'h100, 1, 32'h104, 0, 0);
        vecs[15] = mk(1, 32'h200, 1, 1, 0, 0,    0, 32'h108, 1, 32'h100);
        vecs[16] = mk(0, 0,     1, 1, 1, 32'h104, 1, 32'h200, 0, 0);
        vecs[17] = mk(0, 0,     1, 1, 1, 32'h200, 1, 32'h204, 0, 0);
        vecs[18] = mk(0, 0,     1, 0, 0, 0,      0, 32'h208, 1, 32'h200);

        rst_n = 1'b0; npc = 0; redirect = 0; redirect_pc = 0; imem_req_ready = 0;
        imem_resp_valid = 0; imem_resp_inst = 0; id_ready = 0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            redirect        = vecs[i].rd;
            redirect_pc     = vecs[i].rpc;
            id_ready        = vecs[i].idr;
            imem_req_ready  = vecs[i].rdy;
            imem_resp_valid = vecs[i].rv;
            imem_resp_inst  = inst_of(vecs[i].raddr);
            npc             = vecs[i].e_addr + 32'd4;
            #1;
            chk($sformatf("vec%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_req});
            chk($sformatf("vec%0d req_addr", i), imem_req_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d current_pc", i), current_pc, vecs[i].e_addr);
            chk($sformatf("vec%0d stop_IF", i), {31'b0, stop_IF},
                {31'b0, !(vecs[i].e_req && vecs[i].rdy)});
            chk($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_ifv});
            if (vecs[i].e_ifv) begin
                chk($sformatf("vec%0d if_pc", i), if_pc, vecs[i].e_ifpc);
                chk($sformatf("vec%0d if_inst", i), if_inst, inst_of(vecs[i].e_ifpc));
            end
            @(negedge clk);
        end

        // Two requests in flight, then a reset lands before either response.
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset2");
        @(negedge clk);
        rst_n = 1'b1; redirect = 0; imem_resp_valid = 0; id_ready = 1; imem_req_ready = 1;
        npc = 32'h4;
        #1;
        chk("inflight a addr", imem_req_addr, 32'h0);
        chk("inflight a valid", {31'b0, imem_req_valid}, 32'd1);
        @(negedge clk);
        npc = 32'h8;
        #1;
        chk("inflight b addr", imem_req_addr, 32'h4);
        chk("inflight b valid", {31'b0, imem_req_valid}, 32'd1);
        @(negedge clk);
        #1;
        chk("credit full", {31'b0, imem_req_valid}, 32'd0);
        chk("credit stop_IF", {31'b0, stop_IF}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        model_clear();
        cyc = 0;
        for (int i = 0; i < 1500; i++) random_cycle();

        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rndreset");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 1500; i++) random_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
